// File: rtl/sequence_detector_0110_moore_pkg.sv
// Shared types for the 0110 serial pattern detector: state encoding and the pattern itself.
`timescale 1ns/1ps
package seqdet_pkg;

    // Each state is named after the longest prefix of the pattern matched so far.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S0     = 3'd1,
        S01    = 3'd2,
        S011   = 3'd3,
        DETECT = 3'd4
    } state_t;

    localparam int          PATTERN_LEN = 4;
    localparam logic [3:0]  PATTERN     = 4'b0110;

endpackage

// File: rtl/sequence_detector_0110_moore.sv
// Moore FSM that pulses y for one cycle after the serial stream x delivers 0-1-1-0 (oldest bit first).
`timescale 1ns/1ps
module sequence_detector_0110_moore
    import seqdet_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic y
);

    state_t state;
    state_t nextState;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Unused codes 5-7 fall into the default branch and recover to IDLE.
    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE:    nextState = x ? IDLE : S0;
            S0:      nextState = x ? S01  : S0;
            S01:     nextState = x ? S011 : S0;
            S011:    nextState = x ? IDLE : DETECT;
            DETECT: begin
                if (!x) begin
                    nextState = S0;
                end else begin
                    nextState = OVERLAP ? S01 : IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign y = (state == DETECT);

    // The last bit of PATTERN is what completes a match from S011.
    assert property (@(posedge clk) (rst && state == S011 && x == PATTERN[0]) |=> y);
    assert property (@(posedge clk) (rst && state == DETECT) |=> !y);

endmodule

// File: tb/tb_sequence_detector_0110_moore.sv
// Self-checking bench: runs an overlapping and a non-overlapping detector side by side against tables and a shift-register model.
`timescale 1ns/1ps
module tb_sequence_detector_0110_moore;

    logic clk = 1'b0;
    logic rst;
    logic x;
    logic yOv;
    logic yNo;

    always #5 clk = ~clk;

    sequence_detector_0110_moore #(.OVERLAP(1'b1)) dutOv (.clk(clk), .rst(rst), .x(x), .y(yOv));
    sequence_detector_0110_moore #(.OVERLAP(1'b0)) dutNo (.clk(clk), .rst(rst), .x(x), .y(yNo));

    typedef struct {
        logic rstVal;
        logic xVal;
        logic expOv;
        logic expNo;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    logic [3:0] histOv = 4'hF;
    logic [3:0] histNo = 4'hF;
    logic       modOv  = 1'b0;
    logic       modNo  = 1'b0;

    localparam logic [3:0] PAT = 4'b0110;

    function automatic void addRow(input logic r, input logic b, input logic eo, input logic en);
        vec_t v;
        v.rstVal = r;
        v.xVal   = b;
        v.expOv  = eo;
        v.expNo  = en;
        vecs.push_back(v);
    endfunction

    // Reset fills the history with 1s so no match can borrow bits from before reset.
    task automatic modelStep(input logic r, input logic b);
        logic [3:0] h;
        if (!r) begin
            histOv = 4'hF;
            histNo = 4'hF;
            modOv  = 1'b0;
            modNo  = 1'b0;
        end else begin
            h      = {histOv[2:0], b};
            modOv  = (h == PAT);
            histOv = h;
            h      = {histNo[2:0], b};
            modNo  = (h == PAT);
            histNo = modNo ? 4'hF : h;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic b);
        rst = r;
        x   = b;
        @(posedge clk);
        modelStep(r, b);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    initial begin
        logic seqX[10];
        logic seqR[10];
        logic seqY[10];
        logic prevOv;
        logic prevNo;
        logic r;
        logic b;

        rst = 1'b0;
        x   = 1'b0;

        // Reset held with x toggling, then first cycle out of reset.
        addRow(0, 0, 0, 0);
        addRow(0, 1, 0, 0);
        addRow(1, 1, 0, 0);
        // Basic match.
        addRow(0, 0, 0, 0);
        addRow(1, 0, 0, 0); addRow(1, 1, 0, 0); addRow(1, 1, 0, 0); addRow(1, 0, 1, 1);
        addRow(0, 1, 0, 0);
        // Back-to-back: overlap gives a second pulse three cycles later.
        addRow(1, 0, 0, 0); addRow(1, 1, 0, 0); addRow(1, 1, 0, 0); addRow(1, 0, 1, 1);
        addRow(1, 1, 0, 0); addRow(1, 1, 0, 0); addRow(1, 0, 1, 0);
        addRow(0, 0, 0, 0);
        // Near misses: 0111 drops to IDLE, 010 and 00 recover to S0.
        addRow(1, 0, 0, 0); addRow(1, 1, 0, 0); addRow(1, 1, 0, 0); addRow(1, 1, 0, 0);
        addRow(1, 0, 0, 0); addRow(1, 1, 0, 0); addRow(1, 0, 0, 0); addRow(1, 0, 0, 0);
        addRow(1, 1, 0, 0); addRow(1, 1, 0, 0); addRow(1, 0, 1, 1);
        addRow(1, 1, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstVal, vecs[i].xVal);
            checkOutput($sformatf("vec%0d_ov", i), yOv, vecs[i].expOv);
            checkOutput($sformatf("vec%0d_no", i), yNo, vecs[i].expNo);
        end

        // Mid-sequence reset on the edge that would have completed 0110.
        applyStimulus(0, 0);
        seqR = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        seqX = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1};
        seqY = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(seqR[i], seqX[i]);
            checkOutput($sformatf("midrst%0d_ov", i), yOv, seqY[i]);
            checkOutput($sformatf("midrst%0d_no", i), yNo, seqY[i]);
        end

        // Random stream with occasional reset pulses, checked every cycle.
        applyStimulus(0, 0);
        prevOv = 1'b0;
        prevNo = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            r = ($urandom_range(0, 49) != 0);
            b = 1'($urandom_range(0, 1));
            applyStimulus(r, b);
            checkOutput($sformatf("rand%0d_ov", i), yOv, modOv);
            checkOutput($sformatf("rand%0d_no", i), yNo, modNo);
            if (prevOv) checkOutput($sformatf("rand%0d_ov_width", i), yOv, 1'b0);
            if (prevNo) checkOutput($sformatf("rand%0d_no_width", i), yNo, 1'b0);
            prevOv = yOv;
            prevNo = yNo;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequence_detector_0110_moore.md
Name: sequence_detector_0110_moore

Overview:
Moore-type finite state machine that watches a serial bit stream `x`, sampled one bit per rising clock edge. It asserts `y` for exactly one clock cycle after the pattern 0-1-1-0 has been received, oldest bit first. It is a leaf block used as a serial pattern detector in control and monitoring paths. Output `y` depends only on the current state, never on `x` directly.

Parameters:
OVERLAP, 1, 1 = overlapping detection (the final 0 of a match may start the next match); 0 = non-overlapping (the search restarts from scratch after each match).

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-low (0 = reset), sampled on the rising edge of clk
x    input  1  serial data bit, sampled on every rising edge of clk
y    output 1  detection flag; high for one cycle while in the DETECT state

Interface (Already decided):
- One clock.
- Reset is synchronous and active-low.
- Ports are named clk and rst.

Behaviour:
- States, each named after the longest matched prefix:
  - IDLE: nothing matched
  - S0: "0" matched
  - S01: "01" matched
  - S011: "011" matched
  - DETECT: "0110" matched
- Reset:
  - rst==0 at a rising edge sets the state to IDLE.
  - y==0 in the following cycle.
  - Reset overrides x.
  - Reset asserted mid-sequence discards all partial progress.
  - While rst is held low, the FSM stays in IDLE and y stays 0.
- Transitions when rst==1 (written as x=0 -> next, x=1 -> next):
  - IDLE: 0 -> S0, 1 -> IDLE
  - S0: 0 -> S0, 1 -> S01
  - S01: 0 -> S0, 1 -> S011
  - S011: 0 -> DETECT, 1 -> IDLE
  - DETECT with OVERLAP=1: 0 -> S0, 1 -> S01
  - DETECT with OVERLAP=0: 0 -> S0, 1 -> IDLE
- Output:
  - y = 1 if and only if state == DETECT.
  - y is decoded from the state register only, so it carries no combinational path from x.
  - y goes high in the cycle after the edge that samples the final 0.
  - y stays high for exactly one cycle, because DETECT always exits on the next edge.
- Back-to-back matches (OVERLAP=1): the stream 0110110 produces two single-cycle pulses that are 3 cycles apart.
- Encoding:
  - Binary, 3-bit state register.
  - Unused codes 5–7 return to IDLE on the next edge, with y=0.
- The state register is the only storage element.

Decomposition:
- Shared package `seqdet_pkg`:
  - state enum typedef: IDLE, S0, S01, S011, DETECT, 3-bit
  - localparam for the 4-bit pattern 4'b0110, for documentation and assertion use
- No sub-module. The block is a single next-state process plus a registered state plus an output decode.
- The bench carries a golden reference model: a 4-bit shift register compared against 0110, with an overlap/clear rule matching OVERLAP.

Test Plan:
1. Reset:
   - Stimulus: rst=0 for 2 cycles with x toggling.
   - Required: state IDLE, y=0 throughout; y=0 on the first cycle after rst=1.
2. Basic match:
   - Stimulus: rst=1, x = 0,1,1,0.
   - Required: y=1 exactly in the cycle after the 4th sample edge, then 0.
3. Overlap (OVERLAP=1):
   - Stimulus: x = 0,1,1,0,1,1,0.
   - Required: y pulses after the 4th and 7th samples.
   - Same stimulus with OVERLAP=0: y pulses only after the 4th sample.
4. Near misses:
   - Stimulus: x = 0,1,1,1,0,1,0,0,1,1,0.
   - Required: a single y pulse, after the 11th sample only (IDLE after 0111; S0 recovery on 010 and 00).
5. Mid-sequence reset:
   - Stimulus: x = 0,1,1, then rst=0 for one edge, then x = 0.
   - Required: no y pulse.
   - Follow with 0,1,1,0 -> one pulse.
6. Random:
   - Stimulus: 10k random bits with occasional rst=0 pulses.
   - Required: y matches the golden model every cycle, and y is never high for two consecutive cycles.
